hazard_scoreboard_ctrl: RTL

Parametrised successor to the pipeline stall controller. It keeps a registered scoreboard of in-flight destination registers and decodes the ID-stage instruction against it. From that it produces stall, bubble and flush controls, plus optional forwarding selects. It sits beside the IF/ID and ID/EX pipeline registers and drives PC enable, IF/ID enable and the NOP-insert controls.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_ctrl_instr_regdecode.sv | 32 +++
 rtl/hazard_scoreboard_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared opcodes, scoreboard entry and control modes
package hazard_pkg;
  localparam int SB_REG_W = 5;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b111111;
  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rdst;
    logic                is_load;
  } sb_entry_t;
  typedef enum logic [1:0] {RUN, HSTALL, JBUB, FLUSH} state_t;
endpackage

// File: rtl/hazard_scoreboard_ctrl_instr_regdecode.sv
// instr_regdecode: source/destination register extraction for one instruction
module instr_regdecode import hazard_pkg::*; #(
  parameter int REG_W = 5
) (
  input  logic [31:0]      instr,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] dst,
  output logic             rs_v,
  output logic             rt_v,
  output logic             dst_v,
  output logic             is_load,
  output logic             is_jump
);
  logic [5:0] op;
  logic is_r, is_i, is_st;
  logic unused_bits;
  assign op = instr[31:26];
  assign rs = instr[21 +: REG_W];
  assign rt = instr[16 +: REG_W];
  assign is_r = op == OP_RTYPE;
  assign is_i = op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LW};
  assign is_st = op inside {OP_SW, OP_BEQ, OP_BNE};
  assign is_load = op == OP_LW;
  assign is_jump = op == OP_J;
  // register 0 is hard-wired, so it never creates a dependency
  assign rs_v = (is_r || is_i || is_st) && rs != '0;
  assign rt_v = (is_r || is_st) && rt != '0;
  assign dst = is_r ? instr[11 +: REG_W] : rt;
  assign dst_v = (is_r || is_i) && dst != '0;
  assign unused_bits = ^instr;
endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: in-flight destination scoreboard driving stall/flush/forward controls
module hazard_scoreboard_ctrl import hazard_pkg::*; #(
  parameter int REG_W        = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int FORWARD_EN   = 0,
  parameter int JUMP_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_nop,
  output logic        idex_nop,
  output logic        exmem_nop,
  output logic [2:0]  fwd_a,
  output logic [2:0]  fwd_b,
  output logic [15:0] stall_cnt
);
  logic [REG_W-1:0] rs, rt, dst;
  logic rs_v, rt_v, dst_v, is_load, is_jump;
  sb_entry_t sb [1:PIPE_DEPTH];
  sb_entry_t nxt;
  logic [PIPE_DEPTH:1] ma, mb;
  logic [2:0] ya, yb;
  logic [1:0] jcnt;
  logic haz;
  state_t st;
  instr_regdecode #(.REG_W(REG_W)) u_dec (
    .instr(id_instr), .rs(rs), .rt(rt), .dst(dst),
    .rs_v(rs_v), .rt_v(rt_v), .dst_v(dst_v), .is_load(is_load), .is_jump(is_jump)
  );
  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_match
    assign ma[k] = rs_v && sb[k].valid && sb[k].rdst == SB_REG_W'(rs);
    assign mb[k] = rt_v && sb[k].valid && sb[k].rdst == SB_REG_W'(rt);
  end
  // with forwarding only a load still in EX cannot supply its result in time
  assign haz = FORWARD_EN != 0 ? ((ma[1] || mb[1]) && sb[1].is_load) : (|ma || |mb);
  always_comb begin
    ya = '0;
    yb = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (ma[k]) ya = 3'(k);
      if (mb[k]) yb = 3'(k);
    end
  end
  always_comb begin
    st = !rst_n ? RUN : branch_taken ? FLUSH : haz ? HSTALL : (is_jump || jcnt != '0) ? JBUB : RUN;
    pc_en = st != HSTALL;
    ifid_en = st != HSTALL;
    ifid_nop = st == JBUB || st == FLUSH;
    idex_nop = st == HSTALL || st == FLUSH;
    exmem_nop = st == FLUSH;
    fwd_a = (FORWARD_EN != 0 && rst_n && !haz) ? ya : '0;
    fwd_b = (FORWARD_EN != 0 && rst_n && !haz) ? yb : '0;
  end
  assign nxt = '{valid: (st == RUN || st == JBUB) && dst_v, rdst: SB_REG_W'(dst), is_load: is_load};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) sb[k] <= '0;
      jcnt <= '0;
      stall_cnt <= '0;
    end else begin
      sb[1] <= nxt;
      for (int k = 2; k <= PIPE_DEPTH; k++) sb[k] <= sb[k-1];
      jcnt <= st == FLUSH ? '0 : (st == JBUB && is_jump) ? 2'(JUMP_BUBBLES - 1) : jcnt - 2'(jcnt != '0);
      stall_cnt <= stall_cnt + 16'(st == HSTALL && stall_cnt != 16'hFFFF);
    end
  end
endmodule
